// File: rtl/nanov_mul_seq.sv
// Self-sequencing shift-add multiplier for the nanoV datapath (MUL/MULH/MULHSU/MULHU).
// Retires one multiplier bit per cycle; the result is readable in parallel or shifted out LSB-first on d.
module nanov_mul_seq #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    input  logic             read_out,
    output logic             d
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [W2-1:0]    accum_q, accum_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             hi_q, hi_d;
    logic             done_q, done_d;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] mplier_shr;
    logic             last_iter;
    logic [W2-1:0]    prod;

    // Operand signs and magnitudes; the most negative value negates to itself, which is
    // exactly its magnitude when read as unsigned.
    assign sa         = ((op == 2'b01) || (op == 2'b10)) ? a[WIDTH-1] : 1'b0;
    assign sb         = (op == 2'b01) ? b[WIDTH-1] : 1'b0;
    assign a_abs      = sa ? ('0 - a) : a;
    assign b_abs      = sb ? ('0 - b) : b;
    assign mplier_shr = mplier_q >> 1;
    assign last_iter  = (cnt_q == CW'(WIDTH - 1)) ||
                        ((EARLY_EXIT != 0) && (mplier_shr == '0));
    assign prod       = neg_q ? ('0 - accum_q) : accum_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_MUL;
            S_MUL:   if (last_iter) state_d = S_SIGN;
            S_SIGN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_MUL:   busy = 1'b1;
            S_SIGN:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Datapath next-values
    always_comb begin
        mcand_d  = mcand_q;
        accum_d  = accum_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_abs};
                    mplier_d = b_abs;
                    accum_d  = '0;
                    neg_d    = sa ^ sb;
                    hi_d     = (op != 2'b00);
                    cnt_d    = '0;
                end else if (read_out && !done_q) begin
                    // Serial read-out is frozen during the done cycle so the fresh result is seen intact.
                    result_d = result_q >> 1;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    accum_d = accum_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CW'(1);
            end
            S_SIGN: begin
                result_d = hi_q ? prod[W2-1:WIDTH] : prod[WIDTH-1:0];
                done_d   = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mcand_q  <= '0;
            accum_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            accum_q  <= accum_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign d      = result_q[0];

endmodule

// File: tb/tb_nanov_mul_seq.sv
// Bench for nanov_mul_seq: vector table plus scoreboard, serial read, abort and handshake corner cases.
// Drives an EARLY_EXIT=1 instance for most checks and an EARLY_EXIT=0 instance for fixed latency.
module tb_nanov_mul_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         start1 = 1'b0;
    logic         read_out = 1'b0;
    logic         read_out1 = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, d;
    logic         busy1, done1, d1;
    logic [W-1:0] result, result1;

    always #5 clk = ~clk;

    nanov_mul_seq #(.WIDTH(W), .EARLY_EXIT(1)) dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .read_out(read_out), .d(d)
    );

    nanov_mul_seq #(.WIDTH(W), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .rstn(rstn), .start(start1), .op(op), .a(a), .b(b),
        .busy(busy1), .done(done1), .result(result1), .read_out(read_out1), .d(d1)
    );

    typedef struct {
        string        name;
        logic [W-1:0] res;
    } sb_t;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
    } vec_t;

    sb_t  sb_q[$];
    sb_t  sb1_q[$];
    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // Reference product via 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [W-1:0] model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
        logic [63:0] xe, ye, p;
        xe = ((o == 2'b01) || (o == 2'b10)) ? {{32{x[31]}}, x} : {32'b0, x};
        ye = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = xe * ye;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(logic [1:0] o, logic [W-1:0] y);
        logic [W-1:0] m;
        int k;
        m = ((o == 2'b01) && y[31]) ? (32'd0 - y) : y;
        k = 1;
        for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
        return k + 1;
    endfunction

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clk) begin
        if (rstn && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_done: got done=1 required no pending operation");
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check({e.name, "_result"}, result, e.res);
            end
        end
        if (rstn && done1) begin
            if (sb1_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_done_full: got done=1 required no pending operation");
            end else begin
                sb_t e;
                e = sb1_q.pop_front();
                check({e.name, "_result"}, result1, e.res);
            end
        end
    end

    task automatic run_op(input bit full, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] er, input int el,
                          input string name);
        int  cyc;
        int  bsy;
        sb_t e;
        e.name = name;
        e.res  = er;
        @(negedge clk);
        op = o; a = av; b = bv;
        if (full) begin start1 = 1'b1; sb1_q.push_back(e); end
        else      begin start  = 1'b1; sb_q.push_back(e);  end
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        cyc = 0; bsy = 0;
        while (!(full ? done1 : done) && cyc < 200) begin
            if (full ? busy1 : busy) bsy++;
            @(negedge clk);
            cyc++;
        end
        if (!(full ? done1 : done)) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no done in %0d cycles required done at %0d", name, cyc, el);
        end else begin
            check({name, "_latency"}, cyc, el);
            check({name, "_busy_cycles"}, bsy, el);
            check({name, "_busy_in_done"}, full ? busy1 : busy, 0);
            $display("txn %s op=%0d a=0x%h b=0x%h result=0x%h latency=%0d", name, o, av, bv,
                     full ? result1 : result, cyc);
        end
    endtask

    initial begin
        logic [W-1:0] got;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        int           ndone;

        vecs[0] = '{"mul_7x6",       2'b00, 32'd7,          32'd6,          32'd42,         4};
        vecs[1] = '{"mulh_min_min",  2'b01, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33};
        vecs[2] = '{"mulhu_max",     2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33};
        vecs[3] = '{"mulhsu_m1",     2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  33};
        vecs[4] = '{"mulh_m1_m1",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          2};
        vecs[5] = '{"mul_m3x5",      2'b00, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  4};
        vecs[6] = '{"mul_b0",        2'b00, 32'h1234_5678,  32'd0,          32'h0,          2};
        vecs[7] = '{"mulhu_b0",      2'b11, 32'hDEAD_BEEF,  32'd0,          32'h0,          2};
        vecs[8] = '{"mul_a5x1",      2'b00, 32'hA5A5_A5A5,  32'd1,          32'hA5A5_A5A5,  2};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_d", d, 0);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name);

        // Serial read of 0xA5A5A5A5; the done cycle itself must not shift.
        read_out = 1'b1;
        @(negedge clk);
        check("read_in_done_ignored", result, 32'hA5A5_A5A5);
        for (int i = 0; i < W; i++) begin
            got[i] = d;
            @(negedge clk);
        end
        read_out = 1'b0;
        check("serial_d_bits", got, 32'hA5A5_A5A5);
        check("serial_then_zero", result, 0);
        $display("txn serial_read bits=0x%h result_after=0x%h", got, result);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(1'b0, ro, ra, rb, model(ro, ra, rb), model_lat(ro, rb), $sformatf("rand%0d", i));
        end

        // Start with read_out, read_out while busy, and a second start while busy.
        run_op(1'b0, 2'b00, 32'd7, 32'd6, 32'd42, 4, "pre_mid");
        @(negedge clk);
        op = 2'b11; a = 32'd3; b = 32'h8000_0000; start = 1'b1; read_out = 1'b1;
        begin sb_t e; e.name = "mid_start"; e.res = 32'd1; sb_q.push_back(e); end
        @(negedge clk);
        start = 1'b0;
        check("start_wins_no_shift", result, 42);
        repeat (5) @(negedge clk);
        check("read_busy_ignored", result, 42);
        op = 2'b11; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; read_out = 1'b0;
        ndone = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_start_single_done", ndone, 1);
        $display("txn mid_start result=0x%h dones=%0d", result, ndone);

        // Abort during iteration 10.
        @(negedge clk);
        op = 2'b11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        begin sb_t e; e.name = "aborted"; e.res = 32'hFFFF_FFFE; sb_q.push_back(e); end
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        sb_q.delete();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        $display("txn abort busy=%0d result=0x%h dones=%0d", busy, result, ndone);
        run_op(1'b0, 2'b00, 32'd7, 32'd6, 32'd42, 4, "post_reset");

        // Fixed-latency instance.
        run_op(1'b1, 2'b00, 32'h1234_5678, 32'd0, 32'h0, 33, "full_b0");
        run_op(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "full_mulhu");
        run_op(1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33, "full_m3x5");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb_q.size() + sb1_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
